// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared types and constants for the data-RAM arbiter.
//   state_e    - arbiter FSM states
//   PORT_C/U   - requester indices into the grant/request vectors
//   DEF_*      - default RAM geometry
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_e;

  localparam int unsigned PORT_C = 0;
  localparam int unsigned PORT_U = 1;

  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's request/grant/read-return bundle.
//   master - requester side (drives req/we/addr/wdata, sees gnt/rvalid/rdata)
//   slave  - arbiter side
// AW is the width of the address this requester presents (byte or word).
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int unsigned AW = DEF_ADDR_W,
  parameter int unsigned DW = DEF_DATA_W
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n - clock, async active-low reset
//   req        - raw requests, index PORT_C / PORT_U
//   en         - eligibility mask applied to req
//   update     - advance the last-grant pointer to the current winner
//   gnt        - one-hot grant (combinational)
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] en,
  input  logic       update,
  output logic [1:0] gnt
);

  logic       last_u_q;  // 1: U was granted last
  logic [1:0] elig;

  assign elig = req & en;

  always_comb begin
    gnt = 2'b00;
    unique case (elig)
      // Tie goes to whichever port did not win last time.
      2'b11:   gnt = last_u_q ? 2'b01 : 2'b10;
      default: gnt = elig;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_u_q <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      last_u_q <= gnt[PORT_U];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU (c_bus, byte
// address) and the UART loader (u_bus, word address).
//   clk, rst_n     - clock, async active-low reset
//   prog_mode      - loader owns the RAM exclusively while high
//   c_bus, u_bus   - requester handshakes (slave side)
//   ram_*          - RAM strobe/write/address/data; ram_rdata valid RD_LAT
//                    cycles after a read is issued
//   err_misaligned - one-cycle pulse after accepting a CPU access with
//                    c_addr[1:0] != 0 (access is still performed)
//   busy           - a read is outstanding (RD_WAIT)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_mode,
  dmem_arbiter_if.slave     c_bus,
  dmem_arbiter_if.slave     u_bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              err_misaligned,
  output logic              busy
);

  localparam logic [1:0] CntInit = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              owner_u_q, owner_u_d;  // owner of the in-flight read
  logic [DATA_W-1:0] c_rdata_q, u_rdata_q;
  logic              err_q;

  logic [1:0]        arb_en, gnt;
  logic              accept, acc_we, rd_accept, capture;
  logic [ADDR_W-1:0] c_word;
  logic              unused_c_addr_hi;

  // Upper CPU address bits wrap; bits [1:0] only feed the misalignment flag.
  assign c_word           = c_bus.addr[ADDR_W+1:2];
  assign unused_c_addr_hi = ^c_bus.addr[$bits(c_bus.addr)-1:ADDR_W+2];

  // Nothing is eligible while a read is in flight or reset is held.
  always_comb begin
    arb_en = 2'b00;
    if (rst_n && (state_q != RD_WAIT)) begin
      arb_en = prog_mode ? 2'b10 : 2'b11;
    end
  end

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({u_bus.req, c_bus.req}),
    .en     (arb_en),
    .update (accept),
    .gnt    (gnt)
  );

  assign accept    = gnt[PORT_C] | gnt[PORT_U];
  assign acc_we    = gnt[PORT_C] ? c_bus.we : u_bus.we;
  assign rd_accept = accept && !acc_we;
  assign capture   = (state_q == RD_WAIT) && (cnt_q == 2'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      owner_u_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_u_q <= owner_u_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_u_d = owner_u_q;
    unique case (state_q)
      IDLE, RD_RESP: begin
        if (rd_accept) begin
          state_d   = RD_WAIT;
          cnt_d     = CntInit;
          owner_u_d = gnt[PORT_U];
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    c_bus.gnt    = gnt[PORT_C];
    u_bus.gnt    = gnt[PORT_U];
    c_bus.rvalid = (state_q == RD_RESP) && !owner_u_q;
    u_bus.rvalid = (state_q == RD_RESP) && owner_u_q;
    c_bus.rdata  = c_rdata_q;
    u_bus.rdata  = u_rdata_q;
    ram_en       = accept;
    ram_we       = accept && acc_we;
    ram_addr     = '0;
    ram_wdata    = '0;
    if (gnt[PORT_C]) begin
      ram_addr  = c_word;
      ram_wdata = c_bus.wdata;
    end else if (gnt[PORT_U]) begin
      ram_addr  = u_bus.addr;
      ram_wdata = u_bus.wdata;
    end
    busy           = (state_q == RD_WAIT);
    err_misaligned = err_q;
  end

  // Read-data capture and misalignment flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rdata_q <= '0;
      u_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (capture && !owner_u_q) c_rdata_q <= ram_rdata;
      if (capture && owner_u_q)  u_rdata_q <= ram_rdata;
      err_q <= gnt[PORT_C] && (c_bus.addr[1:0] != 2'b00);
    end
  end

endmodule
